// File: rtl/formant_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// formant_pkg : FSM state encoding and saturation constant
// Rev 1.0
// ------------------------------------------------------------------
package formant_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_TRACE  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    // All-ones source; users slice it down to their cost width.
    localparam logic [63:0] SAT_ALL = {64{1'b1}};

endpackage
`default_nettype wire

// File: rtl/formant_segmenter_sat_add_min.sv
`default_nettype none
// ------------------------------------------------------------------
// sat_add_min : saturating add feeding a running minimum / argmin
// Rev 1.0
// ------------------------------------------------------------------
module sat_add_min
    import formant_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int IW        = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en,
    input  logic                 init,
    input  logic [BIT_WIDTH-1:0] op_a,
    input  logic [BIT_WIDTH-1:0] op_b,
    input  logic [IW-1:0]        idx,
    output logic [BIT_WIDTH-1:0] min_next,
    output logic [IW-1:0]        arg_next
);

    localparam logic [BIT_WIDTH-1:0] SAT = SAT_ALL[BIT_WIDTH-1:0];

    logic [BIT_WIDTH:0]   sum_wide;
    logic [BIT_WIDTH-1:0] sum;
    logic [BIT_WIDTH-1:0] min_q;
    logic [BIT_WIDTH-1:0] min_cur;
    logic [IW-1:0]        arg_q;
    logic [IW-1:0]        arg_cur;

    assign sum_wide = {1'b0, op_a} + {1'b0, op_b};
    assign sum      = (sum_wide[BIT_WIDTH] || (op_a == SAT) || (op_b == SAT))
                      ? SAT : sum_wide[BIT_WIDTH-1:0];

    assign min_cur  = init ? SAT : min_q;
    assign arg_cur  = init ? '0  : arg_q;

    // Strict less-than keeps the earliest index on ties.
    always_comb begin
        min_next = min_cur;
        arg_next = arg_cur;
        if (sum < min_cur) begin
            min_next = sum;
            arg_next = idx;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            min_q <= '0;
            arg_q <= '0;
        end else if (en) begin
            min_q <= min_next;
            arg_q <= arg_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/formant_segmenter.sv
`default_nettype none
// ------------------------------------------------------------------
// formant_segmenter : K-segment DP partition of a frame with traceback
// Rev 1.0
// ------------------------------------------------------------------
module formant_segmenter
    import formant_pkg::*;
#(
    parameter  int BIT_WIDTH    = 32,
    parameter  int I            = 160,
    parameter  int MAX_FORMANTS = 5,
    localparam int IW           = $clog2(I),
    localparam int KW           = $clog2(MAX_FORMANTS + 1)
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [KW-1:0]                    cfg_formants,
    input  logic                             e_valid,
    output logic                             e_ready,
    input  logic [BIT_WIDTH-1:0]             e_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MAX_FORMANTS-1:0][IW-1:0]  out_bound,
    output logic [BIT_WIDTH-1:0]             out_cost,
    output logic                             cfg_error
);

    localparam logic [BIT_WIDTH-1:0] SAT      = SAT_ALL[BIT_WIDTH-1:0];
    localparam logic [IW-1:0]        LAST_BIN = IW'(I - 1);
    localparam logic [KW-1:0]        K_MAX    = KW'(MAX_FORMANTS);

    state_t state;
    state_t next_state;

    logic                 run;
    logic                 accepting;
    logic                 xfer;
    logic                 last_word;
    logic                 trace_done;
    logic                 k_legal;
    logic [KW-1:0]        k_reg;
    logic [KW-1:0]        tk;
    logic                 tphase;
    logic [IW-1:0]        cnt_i;
    logic [IW-1:0]        cnt_j;
    logic [IW-1:0]        rd_addr;
    logic [IW-1:0]        trace_addr;
    logic                 s1_valid;
    logic                 s1_first;
    logic [IW-1:0]        s1_i;
    logic [IW-1:0]        s1_j;
    logic [BIT_WIDTH-1:0] s1_e;
    logic [BIT_WIDTH-1:0] f1_q;
    logic                 wr_en;
    logic [BIT_WIDTH-1:0] sel_f;
    logic [IW-1:0]        sel_b;

    logic [MAX_FORMANTS-1:0][BIT_WIDTH-1:0] f_rd;
    logic [MAX_FORMANTS-1:0][BIT_WIDTH-1:0] f_wdata;
    logic [MAX_FORMANTS-1:1][IW-1:0]        b_rd;

    assign accepting  = run && ((state == ST_IDLE) || (state == ST_ACCEPT));
    assign e_ready    = accepting;
    assign xfer       = e_valid && accepting;
    assign last_word  = (cnt_i == LAST_BIN) && (cnt_j == cnt_i);
    assign k_legal    = (k_reg != '0) && (k_reg <= K_MAX);
    assign trace_done = (state == ST_TRACE) && (!k_legal || (tphase && (tk == '0)));
    assign out_valid  = (state == ST_OUTPUT);
    assign s1_first   = (s1_j == '0);
    assign wr_en      = s1_valid && (s1_j == s1_i);
    assign rd_addr    = (state == ST_TRACE) ? trace_addr
                      : ((cnt_j == '0) ? '0 : cnt_j - IW'(1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
            run   <= 1'b0;
        end else begin
            state <= next_state;
            run   <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (xfer) next_state = last_word ? ST_DRAIN : ST_ACCEPT;
            ST_ACCEPT: if (xfer && last_word) next_state = ST_DRAIN;
            // Last word's bank write commits on the edge leaving DRAIN.
            ST_DRAIN:  next_state = ST_TRACE;
            ST_TRACE:  if (trace_done) next_state = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_i    <= '0;
            cnt_j    <= '0;
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_j     <= '0;
            s1_e     <= '0;
            k_reg    <= '0;
            f1_q     <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_i <= cnt_i;
                s1_j <= cnt_j;
                s1_e <= e_data;
                if (state == ST_IDLE) k_reg <= cfg_formants;
                if (cnt_j == cnt_i) begin
                    cnt_j <= '0;
                    cnt_i <= last_word ? '0 : cnt_i + IW'(1);
                end else begin
                    cnt_j <= cnt_j + IW'(1);
                end
            end
            if (s1_valid && s1_first) f1_q <= s1_e;
        end
    end

    for (genvar b = 0; b < MAX_FORMANTS; b++) begin : g_bank
        logic [BIT_WIDTH-1:0] f_mem [I];
        logic [BIT_WIDTH-1:0] f_q;

        always_ff @(posedge clk_in) begin
            if (wr_en) f_mem[s1_i] <= f_wdata[b];
            f_q <= f_mem[rd_addr];
        end
        assign f_rd[b] = f_q;

        if (b == 0) begin : g_first
            assign f_wdata[b] = s1_first ? s1_e : f1_q;
        end else begin : g_chain
            logic [IW-1:0] b_mem [I];
            logic [IW-1:0] b_q;
            logic [IW-1:0] arg_next;

            // j==0 carries no candidate for k>=2; a SAT operand keeps the min untouched.
            sat_add_min #(
                .BIT_WIDTH (BIT_WIDTH),
                .IW        (IW)
            ) u_sat_add_min (
                .clk_in   (clk_in),
                .rst_in   (rst_in),
                .en       (s1_valid),
                .init     (s1_first),
                .op_a     (s1_first ? SAT : f_rd[b-1]),
                .op_b     (s1_e),
                .idx      (s1_j - IW'(1)),
                .min_next (f_wdata[b]),
                .arg_next (arg_next)
            );

            always_ff @(posedge clk_in) begin
                if (wr_en) b_mem[s1_i] <= arg_next;
                b_q <= b_mem[rd_addr];
            end
            assign b_rd[b] = b_q;
        end
    end

    always_comb begin
        sel_f = f_rd[0];
        sel_b = '0;
        for (int b = 0; b < MAX_FORMANTS; b++)
            if (KW'(b) == tk) sel_f = f_rd[b];
        for (int b = 1; b < MAX_FORMANTS; b++)
            if (KW'(b) == tk) sel_b = b_rd[b];
    end

    // Traceback: two cycles per segment (address issue, then data use).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_bound  <= '0;
            out_cost   <= '0;
            cfg_error  <= 1'b0;
            tk         <= '0;
            tphase     <= 1'b0;
            trace_addr <= '0;
        end else begin
            case (state)
                ST_DRAIN: begin
                    out_bound  <= '0;
                    tk         <= k_reg - KW'(1);
                    tphase     <= 1'b0;
                    trace_addr <= LAST_BIN;
                    for (int b = 0; b < MAX_FORMANTS; b++)
                        if (KW'(b + 1) == k_reg) out_bound[b] <= LAST_BIN;
                    if (!k_legal) cfg_error <= 1'b1;
                end
                ST_TRACE: begin
                    if (!k_legal) begin
                        out_cost <= SAT;
                    end else if (!tphase) begin
                        tphase <= 1'b1;
                    end else begin
                        if (tk == k_reg - KW'(1)) out_cost <= sel_f;
                        if (tk != '0) begin
                            for (int b = 0; b < MAX_FORMANTS - 1; b++)
                                if (KW'(b + 1) == tk) out_bound[b] <= sel_b;
                            trace_addr <= sel_b;
                            tk         <= tk - KW'(1);
                            tphase     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_formant_segmenter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_formant_segmenter : directed self-checking bench, I=4, 16-bit costs
// Rev 1.0
// ------------------------------------------------------------------
module tb_formant_segmenter;

    localparam int BW   = 16;
    localparam int NI   = 4;
    localparam int MAXF = 5;
    localparam int IW   = 2;
    localparam int KW   = 3;

    logic                       clk_in = 1'b0;
    logic                       rst_in = 1'b0;
    logic [KW-1:0]              cfg_formants;
    logic                       e_valid;
    logic                       e_ready;
    logic [BW-1:0]              e_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [MAXF-1:0][IW-1:0]    out_bound;
    logic [BW-1:0]              out_cost;
    logic                       cfg_error;

    int n_checks = 0;
    int n_errors = 0;

    formant_segmenter #(
        .BIT_WIDTH    (BW),
        .I            (NI),
        .MAX_FORMANTS (MAXF)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cfg_formants (cfg_formants),
        .e_valid      (e_valid),
        .e_ready      (e_ready),
        .e_data       (e_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bound    (out_bound),
        .out_cost     (out_cost),
        .cfg_error    (cfg_error)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAXF*IW-1:0] bnd(input int b0, input int b1, input int b2,
                                               input int b3, input int b4);
        logic [MAXF-1:0][IW-1:0] r;
        r[0] = IW'(b0);
        r[1] = IW'(b1);
        r[2] = IW'(b2);
        r[3] = IW'(b3);
        r[4] = IW'(b4);
        return r;
    endfunction

    // 0: i-j, 1: all SAT, 2: (i-j)^2, 3: 0x8000 everywhere
    function automatic logic [BW-1:0] emin(input int pat, input int i, input int j);
        case (pat)
            0:       return BW'(i - j);
            1:       return {BW{1'b1}};
            2:       return BW'((i - j) * (i - j));
            default: return 16'h8000;
        endcase
    endfunction

    task automatic send_frame(input int k, input int pat, input int gaps,
                              input int mid_k, input int max_words);
        int  w;
        int  cnt;
        bit  ok;
        w = 0;
        cfg_formants = KW'(k);
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j <= i; j++) begin
                if (w < max_words) begin
                    if (gaps != 0) begin
                        repeat ($urandom_range(0, 2)) begin
                            e_valid = 1'b0;
                            @(posedge clk_in); #1;
                        end
                    end
                    e_valid = 1'b1;
                    e_data  = emin(pat, i, j);
                    cnt = 0;
                    do begin
                        @(negedge clk_in);
                        ok = e_ready;
                        @(posedge clk_in); #1;
                        cnt++;
                    end while (!ok && cnt < 50);
                    if (!ok) check("e_ready_timeout", 64'(ok), 64'd1);
                    if (w == 0 && mid_k >= 0) cfg_formants = KW'(mid_k);
                    w++;
                end
            end
        end
        e_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [MAXF*IW-1:0] eb,
                              input logic [BW-1:0] ec, input int hold);
        int                  n;
        bit                  stable;
        logic [MAXF*IW-1:0]  b0;
        logic [BW-1:0]       c0;
        n = 0;
        stable = 1'b1;
        do begin
            @(negedge clk_in);
            n++;
        end while (!out_valid && n < 40);
        check({tag, "_valid"},   64'(out_valid), 64'd1);
        check({tag, "_latency"}, 64'(n <= 2 * MAXF + 6), 64'd1);
        check({tag, "_bound"},   64'(out_bound), 64'(eb));
        check({tag, "_cost"},    64'(out_cost), 64'(ec));
        b0 = out_bound;
        c0 = out_cost;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk_in);
                if (!out_valid || out_bound !== b0 || out_cost !== c0) stable = 1'b0;
            end
            check({tag, "_stable"}, 64'(stable), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        e_valid      = 1'b0;
        e_data       = '0;
        cfg_formants = '0;
        out_ready    = 1'b0;

        repeat (2) @(posedge clk_in);
        #1;
        check("rst_e_ready",   64'(e_ready),   64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_cost",  64'(out_cost),  64'd0);
        check("rst_out_bound", 64'(out_bound), 64'd0);
        check("rst_cfg_error", 64'(cfg_error), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("post_rst_e_ready", 64'(e_ready), 64'd1);

        send_frame(2, 0, 0, -1, 100);
        get_result("k2_lin", bnd(0, 3, 0, 0, 0), 16'd2, 0);

        send_frame(1, 0, 0, -1, 100);
        get_result("k1_lin", bnd(3, 0, 0, 0, 0), 16'd3, 0);

        send_frame(2, 1, 0, -1, 100);
        get_result("k2_sat", bnd(0, 3, 0, 0, 0), 16'hFFFF, 0);

        // Gapped stream, K changed after the first word, consumer stalls 20 cycles.
        send_frame(2, 2, 1, 1, 100);
        get_result("k2_sq_gaps", bnd(1, 3, 0, 0, 0), 16'd2, 20);

        out_ready = 1'b1;
        send_frame(4, 0, 0, -1, 100);
        get_result("k4_lin_early_ready", bnd(0, 1, 2, 3, 0), 16'd0, 0);

        send_frame(5, 0, 0, -1, 100);
        get_result("k5_unreachable", bnd(0, 0, 0, 0, 3), 16'hFFFF, 0);

        send_frame(2, 3, 0, -1, 100);
        get_result("k2_overflow", bnd(0, 3, 0, 0, 0), 16'hFFFF, 0);

        send_frame(0, 0, 0, -1, 100);
        get_result("k0_illegal", bnd(0, 0, 0, 0, 0), 16'hFFFF, 0);
        check("k0_cfg_error", 64'(cfg_error), 64'd1);

        send_frame(2, 0, 0, -1, 100);
        get_result("after_k0", bnd(0, 3, 0, 0, 0), 16'd2, 0);
        check("cfg_error_sticky", 64'(cfg_error), 64'd1);

        send_frame(6, 0, 0, -1, 100);
        get_result("k6_illegal", bnd(0, 0, 0, 0, 0), 16'hFFFF, 0);

        // Abort a frame halfway with reset, then run a clean one.
        send_frame(2, 2, 0, -1, 5);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("midrst_e_ready",   64'(e_ready),   64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_cfg_error", 64'(cfg_error), 64'd0);
        check("midrst_out_cost",  64'(out_cost),  64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        send_frame(3, 0, 0, -1, 100);
        get_result("after_rst_k3", bnd(0, 1, 3, 0, 0), 16'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
